stack_core: RTL and testbench

Parametrised successor of the team's 16-bit dual-stack CPU. It fetches 16-bit instruction words over a req/ack memory handshake and executes either one word-format op or two packed byte-format ops per word. It keeps a W-bit data stack and an AW-bit return stack of configurable depth, with full bounds checking. Any stack violation or illegal encoding drives the core into a sticky fault state instead of corrupting state. It sits between the boot ROM/RAM arbiter and the debug/LED output logic.

---
 rtl/stack_core_if.sv | 11 +
 rtl/stack_core.sv | 190 +++++++++++++++++++
 tb/tb_stack_core.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_core_if.sv
// stack_core_if: instruction fetch req/ack bus between the core (master) and memory (slave)
interface stack_core_if #(
    parameter int AW = 16
);
    logic          mem_req;
    logic [AW-2:0] mem_addr;
    logic          mem_ack;
    logic [15:0]   mem_rdata;
    modport master(output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave(input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/stack_core.sv
// stack_core: dual-stack CPU executing word ops or packed byte-op pairs, with sticky fault on any violation
module stack_core #(
    parameter int W      = 16,
    parameter int AW     = 16,
    parameter int DDEPTH = 16,
    parameter int RDEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    stack_core_if.master                  mif,
    output logic                          out_valid_o,
    output logic [W-1:0]                  out_data_o,
    output logic                          halted_o,
    output logic                          fault_o,
    output logic [2:0]                    fault_code_o,
    output logic [$clog2(DDEPTH+1)-1:0]   dsp_o
);
    localparam int DPW = $clog2(DDEPTH + 1);
    localparam int DIW = $clog2(DDEPTH);
    localparam int RPW = $clog2(RDEPTH + 1);
    localparam int RIW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam logic [DPW-1:0] DFULL = DPW'(DDEPTH);
    localparam logic [RPW-1:0] RFULL = RPW'(RDEPTH);

    typedef enum logic [2:0] {FETCH, EXEC_WORD, EXEC_HI, EXEC_LO, HALT, FAULT} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  ip_q, ip_d;
    logic [15:0]    ir_q, ir_d;
    logic [DPW-1:0] dsp_q, dsp_d;
    logic [RPW-1:0] rsp_q, rsp_d;
    logic [W-1:0]   dstk_q [DDEPTH];
    logic [W-1:0]   dstk_d [DDEPTH];
    logic [AW-1:0]  rstk_q [RDEPTH];
    logic [AW-1:0]  rstk_d [RDEPTH];
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [2:0]     code_q, code_d;

    logic [DIW-1:0] i0, i1, i2, i3;
    logic [RIW-1:0] r0, r1;
    logic [W-1:0]   t, n, th, alu;
    logic [7:0]     op;
    logic [1:0]     need;
    logic [2:0]     byte_err, word_err;
    logic [AW-1:0]  target;
    logic           word_fmt;

    // i1 is top of stack, i0 the next free slot
    assign i0 = DIW'(dsp_q);
    assign i1 = DIW'(dsp_q - DPW'(1));
    assign i2 = DIW'(dsp_q - DPW'(2));
    assign i3 = DIW'(dsp_q - DPW'(3));
    assign r0 = RIW'(rsp_q);
    assign r1 = RIW'(rsp_q - RPW'(1));
    assign t  = dstk_q[i1];
    assign n  = dstk_q[i2];
    assign th = dstk_q[i3];

    assign word_fmt = mif.mem_rdata[15:13] != 3'd0;
    assign target   = ip_q + AW'(2) + AW'($signed(ir_q[12:0]));
    assign op       = (state_q == EXEC_HI) ? ir_q[15:8] : ir_q[7:0];
    assign alu      = (op == 8'h01) ? n + t : (op == 8'h02) ? n - t : (op == 8'h09) ? n & t :
                      (op == 8'h0A) ? n | t : n ^ t;
    assign need     = (op == 8'h05) ? 2'd3 :
                      (op inside {8'h01, 8'h02, 8'h04, 8'h09, 8'h0A, 8'h0B}) ? 2'd2 :
                      (op inside {8'h03, 8'h07, 8'h08}) ? 2'd1 : 2'd0;
    // underflow is tested before overflow so the reported code follows that priority
    assign byte_err = (op > 8'h0C) ? 3'd5 : (DPW'(need) > dsp_q) ? 3'd1 :
                      (op == 8'h03 && dsp_q == DFULL) ? 3'd2 : (op == 8'h06 && rsp_q == '0) ? 3'd3 : 3'd0;
    assign word_err = ir_q[15] ? ((dsp_q == DFULL) ? 3'd2 : 3'd0) :
                      (ir_q[14:13] == 2'b10) ? ((rsp_q == RFULL) ? 3'd4 : 3'd0) :
                      (ir_q[14:13] == 2'b11 && dsp_q == '0) ? 3'd1 : 3'd0;

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        ir_d        = ir_q;
        dsp_d       = dsp_q;
        rsp_d       = rsp_q;
        dstk_d      = dstk_q;
        rstk_d      = rstk_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        code_d      = code_q;
        case (state_q)
            FETCH: if (mif.mem_ack) begin
                ir_d    = mif.mem_rdata;
                state_d = word_fmt ? (ip_q[0] ? FAULT : EXEC_WORD) : (ip_q[0] ? EXEC_LO : EXEC_HI);
                code_d  = (word_fmt && ip_q[0]) ? 3'd5 : code_q;
            end
            EXEC_WORD: if (word_err != 3'd0) begin
                state_d = FAULT;
                code_d  = word_err;
            end else begin
                state_d = FETCH;
                ip_d    = ip_q + AW'(2);
                if (ir_q[15]) begin
                    dstk_d[i0] = W'(ir_q[14:0]);
                    dsp_d      = dsp_q + DPW'(1);
                end else if (ir_q[14:13] == 2'b01) begin
                    ip_d = target;
                end else if (ir_q[14:13] == 2'b10) begin
                    rstk_d[r0] = ip_q + AW'(2);
                    rsp_d      = rsp_q + RPW'(1);
                    ip_d       = target;
                end else begin
                    dsp_d = dsp_q - DPW'(1);
                    ip_d  = (t == '0) ? target : ip_q + AW'(2);
                end
            end
            EXEC_HI, EXEC_LO: if (byte_err != 3'd0) begin
                state_d = FAULT;
                code_d  = byte_err;
            end else begin
                state_d = (state_q == EXEC_HI) ? EXEC_LO : FETCH;
                ip_d    = ip_q + AW'(1);
                case (op)
                    8'h01, 8'h02, 8'h09, 8'h0A, 8'h0B: begin
                        dstk_d[i2] = alu;
                        dsp_d      = dsp_q - DPW'(1);
                    end
                    8'h03: begin
                        dstk_d[i0] = t;
                        dsp_d      = dsp_q + DPW'(1);
                    end
                    8'h04: begin
                        dstk_d[i1] = n;
                        dstk_d[i2] = t;
                    end
                    8'h05: begin
                        dstk_d[i1] = th;
                        dstk_d[i2] = t;
                        dstk_d[i3] = n;
                    end
                    8'h06: begin
                        ip_d    = rstk_q[r1];
                        rsp_d   = rsp_q - RPW'(1);
                        state_d = FETCH;
                    end
                    8'h07: begin
                        out_data_d  = t;
                        out_valid_d = 1'b1;
                        dsp_d       = dsp_q - DPW'(1);
                    end
                    8'h08: dsp_d = dsp_q - DPW'(1);
                    8'h0C: state_d = HALT;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            ip_q        <= '0;
            dsp_q       <= '0;
            rsp_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            code_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            dsp_q       <= dsp_d;
            rsp_q       <= rsp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            code_q      <= code_d;
        end
    end

    // stack contents and the instruction latch are only meaningful below the pointers
    always_ff @(posedge clk) begin
        dstk_q <= dstk_d;
        rstk_q <= rstk_d;
        ir_q   <= ir_d;
    end

    assign mif.mem_req  = (state_q == FETCH) & ~rst;
    assign mif.mem_addr = ip_q[AW-1:1];
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign halted_o     = (state_q == HALT) || (state_q == FAULT);
    assign fault_o      = state_q == FAULT;
    assign fault_code_o = code_q;
    assign dsp_o        = dsp_q;
endmodule

// File: tb/tb_stack_core.sv
// tb_stack_core: random and directed programs checked against a queue-based ISA interpreter
module tb_stack_core;
    localparam int DD = 3;
    localparam int RD = 2;

    logic        clk, rst;
    logic        out_valid, halted, fault;
    logic [15:0] out_data;
    logic [2:0]  fault_code;
    logic [1:0]  dsp;
    logic [15:0] mem [128];
    logic [15:0] prog [$];
    logic [15:0] m_outs [$];
    int n_chk, n_err, stalls, wait_cnt, cur_dly, mem_dly;
    int m_term, m_code, m_cyc, m_first, m_dsp;

    stack_core_if #(.AW(8)) mif();

    stack_core #(.W(16), .AW(8), .DDEPTH(DD), .RDEPTH(RD)) dut (
        .clk(clk), .rst(rst), .mif(mif),
        .out_valid_o(out_valid), .out_data_o(out_data), .halted_o(halted),
        .fault_o(fault), .fault_code_o(fault_code), .dsp_o(dsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mif.mem_req && wait_cnt >= cur_dly) begin
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = mem[mif.mem_addr];
            wait_cnt      = 0;
            cur_dly       = (mem_dly < 0) ? int'($urandom_range(2)) : mem_dly;
        end else begin
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = 16'($urandom);
            if (mif.mem_req) begin
                wait_cnt++;
                stalls++;
            end else wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic flt(input int c);
        m_term = 2;
        m_code = c;
    endtask

    task automatic load();
        foreach (mem[i]) mem[i] = 16'h0000;
        foreach (prog[i]) mem[i] = prog[i];
    endtask

    // ISA interpreter: top of stack is the back of the queue
    task automatic model();
        logic [15:0] ds [$];
        int rs [$];
        int ip, tgt, need;
        logic [15:0] w, a, b, c;
        logic [7:0] op;
        logic ret;
        m_outs.delete();
        m_term = 0; m_code = 0; m_cyc = 0; m_first = -1; ip = 0;
        while (m_term == 0 && m_cyc < 1500) begin
            w = mem[ip[7:1]];
            m_cyc++;
            tgt = (ip + 2 + int'($signed(w[12:0]))) & 255;
            if (w[15:13] != 3'd0) begin
                if (ip[0]) flt(5);
                else begin
                    m_cyc++;
                    if (w[15]) begin
                        if (ds.size() == DD) flt(2);
                        else begin
                            ds.push_back({1'b0, w[14:0]});
                            ip = (ip + 2) & 255;
                        end
                    end else if (w[14:13] == 2'b01) ip = tgt;
                    else if (w[14:13] == 2'b10) begin
                        if (rs.size() == RD) flt(4);
                        else begin
                            rs.push_back((ip + 2) & 255);
                            ip = tgt;
                        end
                    end else begin
                        if (ds.size() == 0) flt(1);
                        else ip = (ds.pop_back() == 16'd0) ? tgt : (ip + 2) & 255;
                    end
                end
            end else begin
                for (int h = int'(ip[0]); h < 2 && m_term == 0; h++) begin
                    op = (h == 0) ? w[15:8] : w[7:0];
                    m_cyc++;
                    ret = 1'b0;
                    need = (op == 5) ? 3 : (op inside {1, 2, 4, 9, 10, 11}) ? 2 : (op inside {3, 7, 8}) ? 1 : 0;
                    if (op > 12) flt(5);
                    else if (ds.size() < need) flt(1);
                    else if (op == 3 && ds.size() == DD) flt(2);
                    else if (op == 6 && rs.size() == 0) flt(3);
                    else begin
                        case (op)
                            1: begin c = ds.pop_back(); b = ds.pop_back(); ds.push_back(b + c); end
                            2: begin c = ds.pop_back(); b = ds.pop_back(); ds.push_back(b - c); end
                            9: begin c = ds.pop_back(); b = ds.pop_back(); ds.push_back(b & c); end
                            10: begin c = ds.pop_back(); b = ds.pop_back(); ds.push_back(b | c); end
                            11: begin c = ds.pop_back(); b = ds.pop_back(); ds.push_back(b ^ c); end
                            3: ds.push_back(ds[$]);
                            4: begin c = ds.pop_back(); b = ds.pop_back(); ds.push_back(c); ds.push_back(b); end
                            5: begin
                                c = ds.pop_back(); b = ds.pop_back(); a = ds.pop_back();
                                ds.push_back(b); ds.push_back(c); ds.push_back(a);
                            end
                            6: begin ip = rs.pop_back(); ret = 1'b1; end
                            7: begin
                                m_outs.push_back(ds.pop_back());
                                if (m_first < 0) m_first = m_cyc;
                            end
                            8: void'(ds.pop_back());
                            12: m_term = 1;
                            default: ;
                        endcase
                    end
                    if (ret) h = 2;
                    else ip = (ip + 1) & 255;
                end
            end
        end
        m_dsp = ds.size();
    endtask

    task automatic run_prog(input string name, input int dly, output int first_raw,
                            output logic [15:0] first_val, output logic [2:0] code);
        logic [15:0] got [$];
        int edges, first;
        model();
        mem_dly = dly;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({name, ":rst"}, {mif.mem_req, mif.mem_addr, out_valid, out_data, halted, fault, fault_code, dsp}, 32'd0);
        wait_cnt = 0;
        stalls   = 0;
        cur_dly  = (dly < 0) ? int'($urandom_range(2)) : dly;
        rst = 1'b0;
        #1;
        chk({name, ":start"}, {mif.mem_req, mif.mem_addr}, 8'h80);
        first_raw = -1; first = -1; first_val = 16'd0; edges = 0;
        while (edges < 2000 && !halted) begin
            @(posedge clk);
            #1;
            edges++;
            if (out_valid) begin
                got.push_back(out_data);
                if (first_raw < 0) begin
                    first_raw = edges;
                    first     = edges - stalls;
                    first_val = out_data;
                end
            end
        end
        chk({name, ":halted"}, halted, 1);
        chk({name, ":status"}, {fault, fault_code, dsp}, {m_term == 2, m_code[2:0], m_dsp[1:0]});
        chk({name, ":cycles"}, edges - stalls, m_cyc);
        chk({name, ":n_out"}, got.size(), m_outs.size());
        foreach (m_outs[i]) if (i < got.size()) chk({name, ":out"}, got[i], m_outs[i]);
        if (m_outs.size() > 0) chk({name, ":first_out_cycle"}, first, m_first);
        code = fault_code;
    endtask

    function automatic logic [7:0] rand_op();
        int r;
        r = $urandom_range(40);
        if (r == 40) return 8'($urandom_range(255, 13));
        if (r == 39) return 8'h0C;
        r = r % 12;
        return 8'((r == 6) ? 7 : r);
    endfunction

    function automatic logic [15:0] rand_word();
        if ($urandom_range(9) < 4) return 16'h8000 | 16'($urandom_range(16'h7FFF));
        return {rand_op(), rand_op()};
    endfunction

    initial begin
        int fr, n;
        logic [15:0] fv;
        logic [2:0] fc;
        n_chk = 0; n_err = 0; stalls = 0; wait_cnt = 0; cur_dly = 0; mem_dly = 0;
        rst = 1'b1;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 16'h0000;

        prog = '{16'h8005, 16'h8007, 16'h0107, 16'h0C0C};
        load();
        run_prog("add", 0, fr, fv, fc);
        chk("add:val", fv, 12);
        chk("add:lat", fr, 7);
        run_prog("add_wait", 3, fr, fv, fc);
        chk("add_wait:val", fv, 12);
        chk("add_wait:lat", fr, 16);

        prog = '{16'h8001, 16'h8002, 16'h0207, 16'h0C0C};
        load();
        run_prog("sub", 0, fr, fv, fc);
        chk("sub:val", fv, 16'hFFFF);

        prog = '{16'h8001, 16'h8002, 16'h8003, 16'h0507, 16'h0707, 16'h0C0C};
        load();
        run_prog("rot", 0, fr, fv, fc);
        chk("rot:top", fv, 1);

        prog = '{16'h4004, 16'h8009, 16'h070C, 16'h0600};
        load();
        run_prog("call", 0, fr, fv, fc);
        chk("call:val", fv, 9);

        prog = '{16'h8000, 16'h6002, 16'h8063, 16'h8001, 16'h6002, 16'h8007, 16'h070C};
        load();
        run_prog("cjmp", 1, fr, fv, fc);
        chk("cjmp:val", fv, 7);

        prog = '{16'h8001, 16'h8002, 16'h8003, 16'h8004};
        load();
        run_prog("ovf", 0, fr, fv, fc);
        chk("ovf:code", fc, 2);
        chk("ovf:dsp", dsp, 3);

        prog = '{16'h0100};
        load();
        run_prog("d_unf", 0, fr, fv, fc);
        chk("d_unf:code", fc, 1);

        prog = '{16'h0600};
        load();
        run_prog("r_unf", 0, fr, fv, fc);
        chk("r_unf:code", fc, 3);

        prog = '{16'h2001, 16'h8001};
        load();
        run_prog("odd_word", 0, fr, fv, fc);
        chk("odd_word:code", fc, 5);

        prog = '{16'h0C07};
        load();
        run_prog("halt_hi", 0, fr, fv, fc);
        chk("halt_hi:fault", fault, 0);
        chk("halt_hi:no_out", fr, -1);

        prog = '{16'h8003, 16'h0700, 16'h8005, 16'h0107, 16'h0C0C};
        load();
        mem_dly = 0; cur_dly = 0; wait_cnt = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst:pre", {out_data, 6'(dsp)}, {16'd3, 6'd1});
        #2 rst = 1'b1;
        #1;
        chk("midrst:vals", {mif.mem_req, mif.mem_addr, out_valid, out_data, halted, fault, fault_code, dsp}, 32'd0);
        run_prog("midrst", 0, fr, fv, fc);
        chk("midrst:val", fv, 3);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(20, 4);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(rand_word());
            prog.push_back(16'h0C0C);
            load();
            run_prog("rand", -1, fr, fv, fc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
